// File: rtl/txwregif_pkg.sv
// Shared defaults and helpers for the TX register-interface write-bridge FIFO.
package txwregif_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_PTR   = 2;

    // Ceiling log2, used to confirm PTR matches DEPTH at elaboration.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/txwregif_sfifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module txwregif_sfifo_ram
    import txwregif_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR   = DEF_PTR
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR-1:0]   raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are intentionally not reset; occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/txwregif_sfifo.sv
// Single-clock parametrised FIFO with FWFT/registered read, level flags, flush and sticky errors.
module txwregif_sfifo
    import txwregif_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR    = DEF_PTR,
    parameter int FWFT   = 1,
    parameter int AF_LVL = 3,
    parameter int AE_LVL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             errclr,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    output logic             wrfull,
    output logic             almfull,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             rdempty,
    output logic             almempty,
    output logic [PTR:0]     usedw,
    output logic             ovf,
    output logic             unf,
    output logic             dbg
);

    generate
        if (DEPTH != (1 << PTR) || PTR != clog2(DEPTH) || AF_LVL > DEPTH || AE_LVL >= DEPTH
            || AE_LVL < 0 || AF_LVL < 0) begin : g_bad_params
            $error("txwregif_sfifo: illegal DEPTH/PTR/AF_LVL/AE_LVL combination");
        end
    endgenerate

    localparam logic [PTR:0] DEPTH_C = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AF_C    = (PTR+1)'(AF_LVL);
    localparam logic [PTR:0] AE_C    = (PTR+1)'(AE_LVL);

    logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR:0]     usedw_q, usedw_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] ram_rdata;
    logic             rd_ok, wr_ok, ram_we;

    assign wrfull   = (usedw_q == DEPTH_C);
    assign rdempty  = (usedw_q == '0);
    assign almfull  = (usedw_q >= AF_C);
    assign almempty = (usedw_q <= AE_C);

    // A full FIFO still takes a write when the same cycle pops a word.
    assign rd_ok  = rden & ~rdempty & ~flush;
    assign wr_ok  = wren & (~wrfull | rd_ok) & ~flush;
    assign ram_we = wr_ok & ~reset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dout_d   = dout_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = ram_rdata;
            end
            case ({wr_ok, rd_ok})
                2'b10:   usedw_d = usedw_q + 1'b1;
                2'b01:   usedw_d = usedw_q - 1'b1;
                default: usedw_d = usedw_q;
            endcase
        end

        // Clear first so a coincident new error wins.
        if (errclr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (!flush && wren && !wr_ok) ovf_d = 1'b1;
        if (!flush && rden && rdempty) unf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    txwregif_sfifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR   (PTR)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (datain),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // FWFT output is forced to zero while empty so stale storage never leaks out.
    assign dataout = (FWFT != 0) ? (rdempty ? '0 : ram_rdata) : dout_q;
    assign usedw   = usedw_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign dbg     = ovf_q | unf_q;

endmodule

// File: tb/tb_txwregif_sfifo.sv
// Directed bench: FWFT=1 instance fully checked, FWFT=0 instance on the same stimulus checked for read data.
module tb_txwregif_sfifo;

    logic       clk = 1'b0;
    logic       reset, flush, errclr, wren, rden;
    logic [7:0] datain;

    logic       wrfull, almfull, rdempty, almempty, ovf, unf, dbg;
    logic [7:0] dataout;
    logic [2:0] usedw;

    logic       wrfull_r, almfull_r, rdempty_r, almempty_r, ovf_r, unf_r, dbg_r;
    logic [7:0] dataout_r;
    logic [2:0] usedw_r;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    txwregif_sfifo #(.WIDTH(8), .DEPTH(4), .PTR(2), .FWFT(1), .AF_LVL(3), .AE_LVL(1)) dut_fwft (
        .clk(clk), .reset(reset), .flush(flush), .errclr(errclr),
        .wren(wren), .datain(datain), .wrfull(wrfull), .almfull(almfull),
        .rden(rden), .dataout(dataout), .rdempty(rdempty), .almempty(almempty),
        .usedw(usedw), .ovf(ovf), .unf(unf), .dbg(dbg)
    );

    txwregif_sfifo #(.WIDTH(8), .DEPTH(4), .PTR(2), .FWFT(0), .AF_LVL(3), .AE_LVL(1)) dut_reg (
        .clk(clk), .reset(reset), .flush(flush), .errclr(errclr),
        .wren(wren), .datain(datain), .wrfull(wrfull_r), .almfull(almfull_r),
        .rden(rden), .dataout(dataout_r), .rdempty(rdempty_r), .almempty(almempty_r),
        .usedw(usedw_r), .ovf(ovf_r), .unf(unf_r), .dbg(dbg_r)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; errclr = 0; wren = 0; rden = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); datain = 8'h00;
        cyc(); cyc();
        reset = 0;
        n_checks++; if (usedw !== 3'd0) $display("FAIL reset_usedw got %0d want 0", usedw); else n_pass++;
        n_checks++; if ({rdempty, wrfull, almempty, almfull} !== 4'b1010)
            $display("FAIL reset_flags got %b want 1010", {rdempty, wrfull, almempty, almfull}); else n_pass++;
        n_checks++; if ({ovf, unf, dbg} !== 3'b000) $display("FAIL reset_err got %b want 000", {ovf, unf, dbg}); else n_pass++;
        n_checks++; if (dataout !== 8'h00) $display("FAIL reset_dout got %h want 00", dataout); else n_pass++;
        n_checks++; if (dataout_r !== 8'h00) $display("FAIL reset_dout_reg got %h want 00", dataout_r); else n_pass++;
    endtask

    task automatic test_fill();
        logic [7:0] wd [4];
        wd[0] = 8'hA1; wd[1] = 8'hA2; wd[2] = 8'hA3; wd[3] = 8'hA4;
        for (int i = 0; i < 4; i++) begin
            wren = 1; datain = wd[i];
            cyc();
            n_checks++; if (usedw !== 3'(i + 1)) $display("FAIL fill_usedw[%0d] got %0d want %0d", i, usedw, i + 1); else n_pass++;
            n_checks++; if (dataout !== 8'hA1) $display("FAIL fill_dout[%0d] got %h want a1", i, dataout); else n_pass++;
            n_checks++; if (almfull !== (i >= 2)) $display("FAIL fill_almfull[%0d] got %b want %b", i, almfull, i >= 2); else n_pass++;
            n_checks++; if (wrfull !== (i == 3)) $display("FAIL fill_wrfull[%0d] got %b want %b", i, wrfull, i == 3); else n_pass++;
            n_checks++; if (almempty !== (i == 0)) $display("FAIL fill_almempty[%0d] got %b want %b", i, almempty, i == 0); else n_pass++;
        end
        n_checks++; if (rdempty !== 1'b0) $display("FAIL fill_rdempty got %b want 0", rdempty); else n_pass++;
        idle();
    endtask

    task automatic test_overflow();
        wren = 1; datain = 8'hEE;
        cyc();
        idle();
        n_checks++; if ({ovf, dbg} !== 2'b11) $display("FAIL ovf_set got %b want 11", {ovf, dbg}); else n_pass++;
        n_checks++; if (usedw !== 3'd4) $display("FAIL ovf_usedw got %0d want 4", usedw); else n_pass++;
        n_checks++; if (unf !== 1'b0) $display("FAIL ovf_unf got %b want 0", unf); else n_pass++;
        errclr = 1;
        cyc();
        idle();
        n_checks++; if ({ovf, dbg} !== 2'b00) $display("FAIL ovf_clr got %b want 00", {ovf, dbg}); else n_pass++;
        // Clear and a new overflow in one cycle: the flag must stay set.
        errclr = 1; wren = 1; datain = 8'hEF;
        cyc();
        idle();
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set_wins got %b want 1", ovf); else n_pass++;
        errclr = 1;
        cyc();
        idle();
    endtask

    task automatic test_full_rw();
        logic [7:0] exp [4];
        exp[0] = 8'hA2; exp[1] = 8'hA3; exp[2] = 8'hA4; exp[3] = 8'hB5;
        wren = 1; rden = 1; datain = 8'hB5;
        cyc();
        idle();
        n_checks++; if (usedw !== 3'd4) $display("FAIL fullrw_usedw got %0d want 4", usedw); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL fullrw_ovf got %b want 0", ovf); else n_pass++;
        n_checks++; if (dataout_r !== 8'hA1) $display("FAIL fullrw_pop_reg got %h want a1", dataout_r); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (dataout !== exp[i]) $display("FAIL drain_fwft[%0d] got %h want %h", i, dataout, exp[i]); else n_pass++;
            rden = 1;
            cyc();
            idle();
            n_checks++; if (dataout_r !== exp[i]) $display("FAIL drain_reg[%0d] got %h want %h", i, dataout_r, exp[i]); else n_pass++;
        end
        n_checks++; if ({usedw, rdempty, almempty} !== 5'b00011)
            $display("FAIL drain_end got %b want 00011", {usedw, rdempty, almempty}); else n_pass++;
        n_checks++; if (unf !== 1'b0) $display("FAIL drain_unf got %b want 0", unf); else n_pass++;
    endtask

    task automatic test_empty_rw();
        wren = 1; rden = 1; datain = 8'h3C;
        cyc();
        idle();
        n_checks++; if ({unf, dbg} !== 2'b11) $display("FAIL emptyrw_unf got %b want 11", {unf, dbg}); else n_pass++;
        n_checks++; if (usedw !== 3'd1) $display("FAIL emptyrw_usedw got %0d want 1", usedw); else n_pass++;
        n_checks++; if (dataout !== 8'h3C) $display("FAIL emptyrw_fwft got %h want 3c", dataout); else n_pass++;
        n_checks++; if (dataout_r !== 8'hB5) $display("FAIL emptyrw_reg_hold got %h want b5", dataout_r); else n_pass++;
        rden = 1;
        cyc();
        idle();
        n_checks++; if (dataout_r !== 8'h3C) $display("FAIL emptyrw_reg_read got %h want 3c", dataout_r); else n_pass++;
        n_checks++; if (usedw !== 3'd0) $display("FAIL emptyrw_usedw2 got %0d want 0", usedw); else n_pass++;
        errclr = 1;
        cyc();
        idle();
        n_checks++; if (unf !== 1'b0) $display("FAIL unf_clr got %b want 0", unf); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            wren = 1; datain = 8'(i);
            cyc();
            idle();
            n_checks++; if (dataout !== 8'(i) || usedw !== 3'd1)
                $display("FAIL wrap_wr[%0d] got %h/%0d want %h/1", i, dataout, usedw, 8'(i)); else n_pass++;
            rden = 1;
            cyc();
            idle();
            n_checks++; if (dataout_r !== 8'(i) || usedw !== 3'd0)
                $display("FAIL wrap_rd[%0d] got %h/%0d want %h/0", i, dataout_r, usedw, 8'(i)); else n_pass++;
        end
    endtask

    task automatic test_flush_reset();
        logic [7:0] wd [3];
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            wren = 1; datain = wd[i];
            cyc();
        end
        idle();
        n_checks++; if (usedw !== 3'd3) $display("FAIL flush_pre got %0d want 3", usedw); else n_pass++;
        flush = 1; wren = 1; datain = 8'h44;
        cyc();
        idle();
        n_checks++; if ({usedw, rdempty, ovf} !== 5'b00010)
            $display("FAIL flush got %b want 00010", {usedw, rdempty, ovf}); else n_pass++;
        n_checks++; if (dataout_r !== 8'h09) $display("FAIL flush_reg_hold got %h want 09", dataout_r); else n_pass++;
        flush = 1; rden = 1;
        cyc();
        idle();
        n_checks++; if (unf !== 1'b0) $display("FAIL flush_no_unf got %b want 0", unf); else n_pass++;
        rden = 1;
        cyc();
        idle();
        n_checks++; if (unf !== 1'b1) $display("FAIL post_flush_unf got %b want 1", unf); else n_pass++;
        wren = 1; datain = 8'h55; cyc();
        datain = 8'h66; cyc();
        reset = 1;
        cyc();
        reset = 0; idle();
        n_checks++; if ({usedw, rdempty, wrfull, almempty, almfull} !== 7'b0001010)
            $display("FAIL midreset_flags got %b want 0001010", {usedw, rdempty, wrfull, almempty, almfull}); else n_pass++;
        n_checks++; if ({ovf, unf, dbg} !== 3'b000) $display("FAIL midreset_err got %b want 000", {ovf, unf, dbg}); else n_pass++;
        n_checks++; if (dataout !== 8'h00 || dataout_r !== 8'h00)
            $display("FAIL midreset_dout got %h/%h want 00/00", dataout, dataout_r); else n_pass++;
        wren = 1; datain = 8'h77;
        cyc();
        idle();
        n_checks++; if (dataout !== 8'h77 || usedw !== 3'd1)
            $display("FAIL postreset_wr got %h/%0d want 77/1", dataout, usedw); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_flush_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
